// File: rtl/peb_trace_pkg.sv
// peb_trace_pkg: shared constants and helpers for the PEB trace-capture block.
// Capture FSM state codes, drop-counter width, segment tag field layout and
// a saturating increment used by the per-channel drop counters.
package peb_trace_pkg;

  // Capture FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef logic [1:0] state_t;

  // Width of each per-channel dropped-beat counter
  localparam int DROP_CNT_W = 16;

  // Segment tag layout: {layer[5:0], patch[5:0], ftrgrp[5:0]}
  localparam int TAG_FIELD_W    = 6;
  localparam int TAG_FTRGRP_LSB = 0;
  localparam int TAG_PATCH_LSB  = 6;
  localparam int TAG_LAYER_LSB  = 12;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/peb_trace_fifo.sv
// peb_trace_fifo: synchronous first-word-fall-through FIFO, DEPTH entries.
// head_o shows the oldest entry whenever empty_o is low. A push while full is
// accepted when a pop happens on the same edge.
module peb_trace_fifo
#(
  parameter int W     = 8,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Read/write pointers with wrap bit to tell full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/peb_trace_capture.sv
// peb_trace_capture: records accepted beats on NUM_CH PEB handshake channels
// into a central FIFO, tagged with segment tag, channel and per-channel beat
// index, and streams them out over a val/rdy port.
// Path: fire -> 2-entry channel buffer -> round-robin arbiter -> FIFO -> out_*.
// Handshake: a beat is accepted on a monitored channel when val && rdy (and
// capture enabled); a trace entry pops when out_val && out_rdy, and out_* stay
// stable while out_val && !out_rdy.
// Optional build macro PEB_TRACE_TIMESTAMP_EN adds out_ts, a 32-bit cycle
// stamp taken at each beat's fire edge (counter clears on start).
module peb_trace_capture
  import peb_trace_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 64,
  parameter int TAG_W  = 18,
  parameter int SEQ_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic [TAG_W-1:0]               seg_tag,
  input  logic [NUM_CH-1:0]              ch_en,
  input  logic [NUM_CH-1:0]              ch_val,
  input  logic [NUM_CH-1:0]              ch_rdy,
  input  logic [NUM_CH*DATA_W-1:0]       ch_data,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [DATA_W-1:0]              out_data,
  output logic [$clog2(NUM_CH)-1:0]      out_ch,
  output logic [SEQ_W-1:0]               out_seq,
  output logic [TAG_W-1:0]               out_tag,
`ifdef PEB_TRACE_TIMESTAMP_EN
  output logic [31:0]                    out_ts,
`endif
  output logic [NUM_CH*DROP_CNT_W-1:0]   drop_cnt,
  output logic                           busy,
  output logic                           done,
  output logic [1:0]                     dbg_state
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef struct packed {
`ifdef PEB_TRACE_TIMESTAMP_EN
    logic [31:0]       ts;
`endif
    logic [TAG_W-1:0]  tag;
    logic [SEQ_W-1:0]  seq;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  state_t                  state_q, state_d;
  logic                    start_seg;
  logic [TAG_W-1:0]        tag_q;
  logic [NUM_CH-1:0]       fire;
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*ENTRY_W-1:0] head_flat;
  logic [CH_W-1:0]         rr_q;
  logic                    grant_vld;
  logic [CH_W-1:0]         grant_idx;
  logic [CH_W-1:0]         cand;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_pop;
  logic                    fifo_space;
  logic                    all_empty;
  entry_t                  fifo_in;
  entry_t                  fifo_head;
`ifdef PEB_TRACE_TIMESTAMP_EN
  logic [31:0]             ts_q;
`endif

  assign fire       = (state_q == ST_ARMED) ? (ch_val & ch_rdy & ch_en) : '0;
  assign fifo_pop   = out_val && out_rdy;
  assign fifo_space = !fifo_full || fifo_pop;
  assign all_empty  = !(|req) && fifo_empty;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

  // Next-state logic; stop wins over start when both arrive in ARMED
  always_comb begin
    state_d   = state_q;
    start_seg = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ARMED;
          start_seg = 1'b1;
        end
      end
      ST_ARMED: begin
        if (stop)       state_d   = ST_DRAIN;
        else if (start) start_seg = 1'b1;
      end
      ST_DRAIN: begin
        if (all_empty) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and latched segment tag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_seg) tag_q <= seg_tag;
    end
  end

`ifdef PEB_TRACE_TIMESTAMP_EN
  // Free-running cycle counter, restarted at each new segment
  always_ff @(posedge clk) begin
    if (rst)            ts_q <= '0;
    else if (start_seg) ts_q <= '0;
    else                ts_q <= ts_q + 32'd1;
  end
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]            cnt_q;
    entry_t                slot0_q;
    entry_t                slot1_q;
    entry_t                beat;
    logic [SEQ_W-1:0]      seq_q;
    logic [DROP_CNT_W-1:0] drop_q;
    logic                  push;
    logic                  pop;

    // Full means two entries before the edge, even if one leaves on it
    assign pop  = grant_vld && (grant_idx == CH_W'(g));
    assign push = fire[g] && (cnt_q != 2'd2);

    assign req[g] = (cnt_q != 2'd0);
    assign head_flat[g*ENTRY_W +: ENTRY_W] = slot0_q;
    assign drop_cnt[g*DROP_CNT_W +: DROP_CNT_W] = drop_q;

    // Build the entry for a beat firing this cycle
    always_comb begin
      beat      = '0;
      beat.data = ch_data[g*DATA_W +: DATA_W];
      beat.ch   = CH_W'(g);
      beat.seq  = seq_q;
      beat.tag  = tag_q;
`ifdef PEB_TRACE_TIMESTAMP_EN
      beat.ts   = ts_q;
`endif
    end

    // Occupancy, beat index and saturating drop counter
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        seq_q  <= '0;
        drop_q <= '0;
      end else begin
        cnt_q <= cnt_q + 2'(push) - 2'(pop);
        if (start_seg)    seq_q <= '0;
        else if (fire[g]) seq_q <= seq_q + SEQ_W'(1);
        if (fire[g] && (cnt_q == 2'd2)) drop_q <= sat_inc(drop_q);
      end
    end

    // Two-slot shift buffer: slot0 is the head; a new beat lands in the
    // first slot left free after this cycle's pop
    always_ff @(posedge clk) begin
      if (pop) slot0_q <= slot1_q;
      if (push) begin
        if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)) slot0_q <= beat;
        else                                             slot1_q <= beat;
      end
    end
  end

  // Round-robin search starting at the channel after the last grant
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(rr_q) + k) % NUM_CH);
      if (!grant_vld && fifo_space && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Arbiter pointer
  always_ff @(posedge clk) begin
    if (rst)            rr_q <= '0;
    else if (grant_vld) rr_q <= (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);
  end

  assign fifo_in = head_flat[grant_idx*ENTRY_W +: ENTRY_W];

  peb_trace_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (grant_vld),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Outputs read zero whenever no entry is presented
  assign out_val  = !fifo_empty;
  assign out_data = out_val ? fifo_head.data : '0;
  assign out_ch   = out_val ? fifo_head.ch   : '0;
  assign out_seq  = out_val ? fifo_head.seq  : '0;
  assign out_tag  = out_val ? fifo_head.tag  : '0;
`ifdef PEB_TRACE_TIMESTAMP_EN
  assign out_ts   = out_val ? fifo_head.ts   : '0;
`endif

endmodule

// File: tb/tb_peb_trace_capture.sv
// tb_peb_trace_capture: randomized and directed stimulus for peb_trace_capture,
// checked every cycle against a queue-based reference model of the capture
// path (channel buffers, round-robin drain, central FIFO, segment control).
module tb_peb_trace_capture;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 64;
  localparam int TAG_W  = 18;
  localparam int SEQ_W  = 16;
  localparam int CH_W   = 2;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DRAIN = 2;

  // ---------------- clock / reset / DUT ----------------
  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic                     stop;
  logic [TAG_W-1:0]         seg_tag;
  logic [NUM_CH-1:0]        ch_en;
  logic [NUM_CH-1:0]        ch_val;
  logic [NUM_CH-1:0]        ch_rdy;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     out_val;
  logic                     out_rdy;
  logic [DATA_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic [SEQ_W-1:0]         out_seq;
  logic [TAG_W-1:0]         out_tag;
`ifdef PEB_TRACE_TIMESTAMP_EN
  logic [31:0]              out_ts;
`endif
  logic [NUM_CH*16-1:0]     drop_cnt;
  logic                     busy;
  logic                     done;
  logic [1:0]               dbg_state;

  always #5 clk = ~clk;

  peb_trace_capture #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .SEQ_W  (SEQ_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .seg_tag   (seg_tag),
    .ch_en     (ch_en),
    .ch_val    (ch_val),
    .ch_rdy    (ch_rdy),
    .ch_data   (ch_data),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_seq   (out_seq),
    .out_tag   (out_tag),
`ifdef PEB_TRACE_TIMESTAMP_EN
    .out_ts    (out_ts),
`endif
    .drop_cnt  (drop_cnt),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [31:0]       ts;
    logic [TAG_W-1:0]  tag;
    logic [SEQ_W-1:0]  seq;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t             exp_q[$];
  ent_t             m_buf[NUM_CH][$];
  int               m_seq[NUM_CH];
  int               m_drop[NUM_CH];
  int               m_rr;
  int               m_state;
  logic [TAG_W-1:0] m_tag;
  logic [31:0]      m_ts;

  int n_checks = 0;
  int n_errors = 0;
  int pops;
  int pop_ch[NUM_CH];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_empty();
    bit e;
    e = (exp_q.size() == 0);
    for (int i = 0; i < NUM_CH; i++) if (m_buf[i].size() != 0) e = 0;
    return e;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NUM_CH; i++) begin
      m_buf[i].delete();
      m_seq[i]  = 0;
      m_drop[i] = 0;
    end
    m_rr    = 0;
    m_state = M_IDLE;
    m_tag   = '0;
    m_ts    = '0;
  endtask

  // Advance the model by one clock edge using the inputs now on the pins
  task automatic model_step();
    ent_t nb[NUM_CH];
    bit   nbv[NUM_CH];
    bit   pop_now;
    bit   space;
    bit   was_empty;
    bit   seg;
    int   g;
    if (rst) begin
      model_reset();
      return;
    end
    was_empty = model_empty();
    pop_now   = (exp_q.size() > 0) && out_rdy;
    space     = (exp_q.size() < DEPTH) || pop_now;
    g = -1;
    if (space) begin
      for (int k = 0; k < NUM_CH; k++) begin
        int c;
        c = (m_rr + k) % NUM_CH;
        if (g < 0 && m_buf[c].size() > 0) g = c;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      nbv[i] = 0;
      nb[i]  = '0;
      if (m_state == M_ARMED && ch_val[i] && ch_rdy[i] && ch_en[i]) begin
        if (m_buf[i].size() < 2) begin
          nbv[i]     = 1;
          nb[i].data = ch_data[i*DATA_W +: DATA_W];
          nb[i].ch   = CH_W'(i);
          nb[i].seq  = SEQ_W'(m_seq[i]);
          nb[i].tag  = m_tag;
          nb[i].ts   = m_ts;
        end else if (m_drop[i] < 65535) begin
          m_drop[i]++;
        end
        m_seq[i] = (m_seq[i] + 1) % (1 << SEQ_W);
      end
    end
    if (pop_now) void'(exp_q.pop_front());
    if (g >= 0) begin
      exp_q.push_back(m_buf[g].pop_front());
      m_rr = (g + 1) % NUM_CH;
    end
    for (int i = 0; i < NUM_CH; i++) if (nbv[i]) m_buf[i].push_back(nb[i]);
    seg = 0;
    case (m_state)
      M_IDLE:  if (start) begin m_state = M_ARMED; seg = 1; end
      M_ARMED: if (stop) m_state = M_DRAIN; else if (start) seg = 1;
      default: if (was_empty) m_state = M_IDLE;
    endcase
    if (seg) begin
      m_tag = seg_tag;
      for (int i = 0; i < NUM_CH; i++) m_seq[i] = 0;
    end
    m_ts = seg ? 32'd0 : m_ts + 32'd1;
  endtask

  // Compare every observable output with the model's current state
  task automatic compare();
    check("out_val", out_val, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("out_data", out_data, exp_q[0].data);
      check("out_ch", out_ch, exp_q[0].ch);
      check("out_seq", out_seq, exp_q[0].seq);
      check("out_tag", out_tag, exp_q[0].tag);
`ifdef PEB_TRACE_TIMESTAMP_EN
      check("out_ts", out_ts, exp_q[0].ts);
`endif
    end
    check("busy", busy, m_state != M_IDLE);
    check("done", done, (m_state == M_DRAIN) && model_empty());
    for (int i = 0; i < NUM_CH; i++) check("drop_cnt", drop_cnt[i*16 +: 16], 16'(m_drop[i]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    compare();
    if (out_val && out_rdy) begin
      pops++;
      pop_ch[out_ch]++;
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic clear_pops();
    pops = 0;
    for (int i = 0; i < NUM_CH; i++) pop_ch[i] = 0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_CH; i++)
      ch_data[i*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle_inputs();
    ch_val = '0;
    ch_rdy = '0;
    ch_en  = '0;
  endtask

  task automatic open_segment(input logic [TAG_W-1:0] t);
    seg_tag = t;
    start   = 1'b1;
    tick();
  endtask

  // n consecutive accepted beats on one channel
  task automatic beats(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      rand_data();
      ch_val = '0; ch_val[ch] = 1'b1;
      ch_rdy = '0; ch_rdy[ch] = 1'b1;
      ch_en  = '1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic run_until_empty(input int bound);
    int n;
    n = 0;
    while (!model_empty() && n < bound) begin
      tick();
      n++;
    end
    check("drain_bound", model_empty(), 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int drop0[NUM_CH];
    int done_cnt;

    rst = 1'b1; start = 1'b0; stop = 1'b0; seg_tag = '0;
    out_rdy = 1'b0; ch_data = '0;
    idle_inputs();
    clear_pops();
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;

    // Reset values
    check("rst_out_data", out_data, '0);
    check("rst_out_ch", out_ch, '0);
    check("rst_out_seq", out_seq, '0);
    check("rst_out_tag", out_tag, '0);
    tick();

    // Single channel, 5 beats, latency 2
    out_rdy = 1'b1;
    open_segment(18'h01234);
    clear_pops();
    rand_data();
    ch_val = 4'b0001; ch_rdy = 4'b0001; ch_en = '1;
    tick();
    check("lat_edge1", out_val, 1'b0);
    rand_data();
    tick();
    check("lat_edge2", out_val, 1'b1);
    check("lat_seq", out_seq, '0);
    beats(0, 3);
    run_until_empty(20);
    check("single_pops", pops, 5);

    // All channels every cycle for 8 cycles
    open_segment(18'h2a5c3);
    clear_pops();
    for (int i = 0; i < NUM_CH; i++) drop0[i] = drop_cnt[i*16 +: 16];
    for (int k = 0; k < 8; k++) begin
      rand_data();
      ch_val = '1; ch_rdy = '1; ch_en = '1;
      tick();
    end
    idle_inputs();
    run_until_empty(40);
    for (int i = 0; i < NUM_CH; i++)
      check("all4_drops", drop_cnt[i*16 +: 16] - drop0[i], 8 - pop_ch[i]);

    // FIFO backpressure on ch1
    open_segment(18'h00111);
    out_rdy = 1'b0;
    drop0[1] = drop_cnt[16 +: 16];
    beats(1, 70);
    repeat (4) tick();
    check("bp_drops", drop_cnt[16 +: 16] - drop0[1], 70 - (DEPTH + 2));
    clear_pops();
    out_rdy = 1'b1;
    run_until_empty(100);
    check("bp_pops", pops, DEPTH + 2);

    // Re-segment on ch2
    open_segment(18'h0aaaa);
    clear_pops();
    beats(2, 3);
    open_segment(18'h15555);
    beats(2, 2);
    run_until_empty(20);
    check("reseg_pops", pops, 5);

    // Drain with 10 entries pending
    out_rdy = 1'b0;
    open_segment(18'h3c0f0);
    beats(0, 10);
    repeat (3) tick();
    stop = 1'b1;
    tick();
    check("drain_busy", busy, 1'b1);
    seg_tag = 18'h3ffff;
    start = 1'b1;
    tick();
    clear_pops();
    done_cnt = 0;
    out_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (done) done_cnt++;
      tick();
    end
    check("drain_done_cnt", done_cnt, 1);
    check("drain_pops", pops, 10);
    check("drain_idle", busy, 1'b0);
    beats(3, 4);
    repeat (3) tick();
    check("idle_no_out", out_val, 1'b0);

    // Randomized traffic with occasional re-segmenting
    open_segment(18'(($urandom)));
    for (int k = 0; k < 600; k++) begin
      rand_data();
      ch_val  = 4'($urandom);
      ch_rdy  = 4'($urandom);
      ch_en   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : '1;
      out_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) begin
        start   = 1'b1;
        seg_tag = 18'($urandom);
        ch_val  = '0;
      end
      tick();
    end
    idle_inputs();
    out_rdy = 1'b1;
    stop = 1'b1;
    tick();
    run_until_empty(200);
    tick();
    check("rand_idle", busy, 1'b0);

    // Reset mid-stream with a full FIFO
    out_rdy = 1'b0;
    open_segment(18'h12345);
    beats(0, 70);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_out_val", out_val, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_drop", drop_cnt, '0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/peb_trace_capture.md
# peb_trace_capture

Synthesizable, parametrised trace-capture block that records every accepted beat (val && rdy) on NUM_CH monitored PEB handshake channels into an on-chip FIFO. Each entry is tagged with the current layer/patch/ftrgrp segment tag, channel ID and per-channel beat index. Entries are read out over a val/rdy port. The block sits beside the PEL and replaces simulation-only file dumping with silicon-visible trace for post-silicon debug.

## Interface
Parameters:
- NUM_CH, 4: monitored channels (2–16)
- DATA_W, 128: payload width per channel
- DEPTH, 64: central FIFO entries (power of 2)
- TAG_W, 18: segment tag width ({layer[5:0], patch[5:0], ftrgrp[5:0]})
- SEQ_W, 16: per-channel beat index width

Ports:
- clk  in  1  clock; one clock, all logic on its rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  pulse: open new segment, latch seg_tag
- stop  in  1  pulse: stop capture, drain
- seg_tag  in  TAG_W  segment tag, sampled on start
- ch_en  in  NUM_CH  per-channel capture enable, sampled every cycle
- ch_val  in  NUM_CH  monitored valid
- ch_rdy  in  NUM_CH  monitored ready
- ch_data  in  NUM_CH*DATA_W  monitored payload, channel i at [i*DATA_W +: DATA_W]
- out_val  out  1  trace entry valid
- out_rdy  in  1  trace consumer ready
- out_data  out  DATA_W  captured payload
- out_ch  out  $clog2(NUM_CH)  source channel
- out_seq  out  SEQ_W  beat index within segment
- out_tag  out  TAG_W  segment tag at capture time
- drop_cnt  out  NUM_CH*16  per-channel dropped-beat counters, saturating
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on DRAIN -> IDLE

## Operation
- States: IDLE, ARMED, DRAIN. Reset -> IDLE.
  - IDLE --start--> ARMED.
  - ARMED --stop--> DRAIN.
  - ARMED --start--> ARMED (re-segment).
  - DRAIN --all buffers and FIFO empty--> IDLE, with done=1 for that cycle.
  - start in DRAIN is ignored. stop in IDLE is ignored.
- Fire condition: in ARMED only, for channel i, fire_i = ch_val[i] & ch_rdy[i] & ch_en[i].
- Each channel has a 2-entry input buffer. On fire_i, {data, seq_i, tag} is written and seq_i increments (wraps at 2^SEQ_W).
  - If the buffer is full, the beat is dropped and drop_cnt[i] increments, saturating at 0xFFFF.
  - seq_i increments even on a drop, so gaps in seq are visible to the consumer.
- Round-robin arbiter moves at most one buffered entry per cycle into the FIFO when the FIFO is not full.
  - Priority starts at the channel after the last grant. Reset pointer = 0.
- start in ARMED latches the new tag and clears all seq_i to 0 on the same edge. Entries already buffered keep their old tag. drop_cnt is not cleared.
- drop_cnt clears only on rst.
- A buffer may be written and read in the same cycle. It counts as full only if it holds 2 entries before that edge.

## Timing
- Beat firing at edge t is latched in its channel buffer at t. It enters the FIFO at t+1 at the earliest and shows on out_val from t+2 (minimum latency 2 cycles).
- out_* hold stable while out_val && !out_rdy. An entry pops on out_val && out_rdy.
- FIFO full and pop in the same cycle: the push is allowed.
- Sustained throughput is one entry per cycle total across all channels.
- Reset values: out_val=0, out_data=0, out_ch=0, out_seq=0, out_tag=0, drop_cnt=0, busy=0, done=0.
- rst mid-operation flushes all buffers and the FIFO with no further output.

## Configuration
- PEB_TRACE_TIMESTAMP_EN defined:
  - Adds output out_ts [31:0], a free-running cycle counter that clears on start.
  - Each entry stores the counter value at its fire edge. The counter wraps at 2^32.
  - out_ts resets to 0.
- Undefined: no out_ts port, no counter, no timestamp storage.

## Structure
- Package peb_trace_pkg holds:
  - the state enum (IDLE/ARMED/DRAIN);
  - the trace-entry struct, parametrised through typedef widths in the wrapper;
  - the constant DROP_CNT_W = 16;
  - the tag field offsets.
- One sub-module, peb_trace_fifo: a synchronous FIFO with DEPTH entries and full/empty flags, instantiated once for the central FIFO.
- The 2-entry channel buffers are small enough to stay inline.

## Test plan
- Single channel: start with tag 0x01234, 5 beats on ch0, out_rdy=1 -> 5 entries with ch=0, seq 0..4, tag 0x01234, payloads in order; first out_val 2 cycles after the first fire.
- All 4 channels fire every cycle for 8 cycles, out_rdy=1:
  - drains at 1 entry per cycle in round-robin order ch0,1,2,3,…;
  - drop_cnt per channel = 8 − accepted;
  - seq gaps in the output match the drops exactly.
- FIFO backpressure: out_rdy=0 with 64+ beats on ch1 -> exactly 64 FIFO + 2 buffered entries, the rest counted in drop_cnt[1]; no entry is corrupted after out_rdy rises.
- Re-segment: start with tag A, 3 beats on ch2, start with tag B, 2 beats -> entries tagged A with seq 0..2, then B with seq 0..1.
- Drain: stop with 10 entries pending -> busy stays 1, done pulses once the last entry pops, then IDLE; later beats are ignored.
- Reset mid-stream: rst asserted during ARMED with a full FIFO -> out_val=0 next cycle, IDLE, drop_cnt=0.
